// File: rtl/fd_pipe_reg_pkg.sv
// Shared definitions for the F/D pipeline register and its address-exception checker.
// Exception codes, default PC values and the D-stage register bundle.
package fd_pipe_reg_pkg;

   localparam logic [4:0]  EXC_NONE  = 5'd0;
   localparam logic [4:0]  EXC_ADEL  = 5'd4;
   localparam logic [4:0]  EXC_RI    = 5'd10;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   localparam logic [31:0] FD_RESET_PC  = 32'h0000_3000;
   localparam logic [31:0] FD_EXC_ENTRY = 32'h0000_4180;
   localparam logic [31:0] FD_IM_LO     = 32'h0000_3000;
   localparam logic [31:0] FD_IM_HI     = 32'h0000_6FFC;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc8;
      logic [31:0] instr;
      logic [4:0]  exc;
      logic        bd;
      logic        valid;
   } fd_regs_t;

   // Link value; wraps modulo 2^32 by construction.
   function automatic logic [31:0] pc_link(input logic [31:0] pc);
      return pc + 32'd8;
   endfunction

   // A bubble keeps a meaningful PC but carries no instruction, exception or delay-slot flag.
   function automatic fd_regs_t bubble(input logic [31:0] pc);
      fd_regs_t b;
      b.pc    = pc;
      b.pc8   = pc_link(pc);
      b.instr = NOP_INSTR;
      b.exc   = EXC_NONE;
      b.bd    = 1'b0;
      b.valid = 1'b0;
      return b;
   endfunction

endpackage

// File: rtl/fd_pipe_reg_if.sv
// F/D boundary bundle: pipeline control, fetch-side inputs and decode-side outputs.
// master drives the F side and control; slave is the pipeline register itself.
interface fd_pipe_reg_if;
   logic        stall;
   logic        flush;
   logic        req;
   logic [31:0] F_pc;
   logic [31:0] F_instr;
   logic        F_bd;
   logic [31:0] D_pc;
   logic [31:0] D_pc8;
   logic [31:0] D_instr;
   logic [4:0]  D_exc;
   logic        D_bd;
   logic        D_valid;
   logic [31:0] stall_cnt;

   modport master (
      output stall, flush, req, F_pc, F_instr, F_bd,
      input  D_pc, D_pc8, D_instr, D_exc, D_bd, D_valid, stall_cnt
   );

   modport slave (
      input  stall, flush, req, F_pc, F_instr, F_bd,
      output D_pc, D_pc8, D_instr, D_exc, D_bd, D_valid, stall_cnt
   );
endinterface

// File: rtl/fd_exc_detect.sv
// Combinational address-error check: misaligned word address or outside [im_lo, im_hi].
// Shared with the M-stage load address check, so the window comes in as ports.
module fd_exc_detect
   import fd_pipe_reg_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] im_lo,
   input  logic [31:0] im_hi,
   output logic [4:0]  exc
);

   logic misaligned;
   logic out_of_range;

   assign misaligned   = (pc[1:0] != 2'b00);
   assign out_of_range = (pc < im_lo) || (pc > im_hi);
   assign exc          = (misaligned || out_of_range) ? EXC_ADEL : EXC_NONE;

endmodule

// File: rtl/fd_pipe_reg.sv
// F/D pipeline register with priority reset > req > flush > stall > load.
// Define FD_STALL_CNT_EN to build the saturating stall-cycle counter; otherwise stall_cnt reads 0.
module fd_pipe_reg
   import fd_pipe_reg_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = FD_RESET_PC,
   parameter logic [31:0] EXC_ENTRY = FD_EXC_ENTRY,
   parameter logic [31:0] IM_LO     = FD_IM_LO,
   parameter logic [31:0] IM_HI     = FD_IM_HI
)
(
   input  logic          clk,
   input  logic          reset,
   fd_pipe_reg_if.slave  bus
);

   fd_regs_t   d_q;
   fd_regs_t   d_nxt;
   fd_regs_t   load_val;
   logic [4:0] f_exc;

   fd_exc_detect u_exc_detect (
      .pc    (bus.F_pc),
      .im_lo (IM_LO),
      .im_hi (IM_HI),
      .exc   (f_exc)
   );

   always_comb begin
      load_val.pc    = bus.F_pc;
      load_val.pc8   = pc_link(bus.F_pc);
      load_val.exc   = f_exc;
      load_val.instr = (f_exc == EXC_NONE) ? bus.F_instr : NOP_INSTR;
      load_val.bd    = bus.F_bd;
      load_val.valid = 1'b1;
   end

   always_comb begin
      d_nxt = d_q;
      if (bus.req) begin
         d_nxt = bubble(EXC_ENTRY);
      end else if (bus.flush) begin
         d_nxt = bubble(bus.F_pc);
      end else if (!bus.stall) begin
         d_nxt = load_val;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         d_q <= bubble(RESET_PC);
      end else begin
         d_q <= d_nxt;
      end
   end

   assign bus.D_pc    = d_q.pc;
   assign bus.D_pc8   = d_q.pc8;
   assign bus.D_instr = d_q.instr;
   assign bus.D_exc   = d_q.exc;
   assign bus.D_bd    = d_q.bd;
   assign bus.D_valid = d_q.valid;

`ifdef FD_STALL_CNT_EN
   logic [31:0] stall_cnt_q;
   logic        stall_hold;

   // Only true holds count; squashed or redirected stall cycles do not.
   assign stall_hold = bus.stall && !bus.req && !bus.flush;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= 32'h0;
      end else if (stall_hold && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign bus.stall_cnt = stall_cnt_q;
`else
   assign bus.stall_cnt = 32'h0;
`endif

endmodule
